// File: rtl/mrd_to_rns_horner.sv
// mrd_to_rns_horner
// Re-encodes a six-digit mixed-radix vector (a4 least significant .. a9) into
// residues modulo three target moduli. The value
//    X = a4 + R4*(a5 + R5*(a6 + R6*(a7 + R7*(a8 + R8*a9))))
// is evaluated by Horner's rule. Each multiply by a radix is done bit-serially,
// MSB first, with single conditional-subtract reductions, so no wide
// multiplier and no intermediate wider than DATA_WIDTH+1 bits is needed.
//
// Ports
//    clk                    rising-edge clock
//    reset                  synchronous, active-high
//    in_valid / in_ready    input handshake; in_ready only while idle
//    Dig_in_4_..Dig_in_9_   mixed-radix digits
//    Sgn_in                 sign sideband, captured on accept
//    out_valid / out_ready  output handshake; outputs hold while stalled
//    Res_out_A/B/C          X mod MOD_A / MOD_B / MOD_C
//    Sgn_out                captured Sgn_in
//    Dig_err                some captured digit was out of range

// One residue channel. Holds the Horner accumulator and the partial product
// of the bit-serial modular multiply. All operands stay below MOD, which must
// exceed 2^(DATA_WIDTH-1) so that a raw digit reduces with one subtract.
module mrd_to_rns_horner_ch #(
   parameter int          DATA_WIDTH = 18,
   parameter int unsigned MOD        = 177147
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_init,
   input  logic                  i_mul,
   input  logic                  i_add,
   input  logic                  i_bit,
   input  logic [DATA_WIDTH-1:0] i_top,
   input  logic [DATA_WIDTH-1:0] i_dig,
   output logic [DATA_WIDTH-1:0] o_acc_nxt
);

   localparam logic [DATA_WIDTH:0] LP_MOD = (DATA_WIDTH+1)'(MOD);

   // Input must be below 2*MOD; result is below MOD.
   function automatic logic [DATA_WIDTH-1:0] f_cond_sub(input logic [DATA_WIDTH:0] v);
      logic [DATA_WIDTH:0] d;
      d = v - LP_MOD;
      if (v >= LP_MOD) return d[DATA_WIDTH-1:0];
      else             return v[DATA_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0] r_t;

   logic [DATA_WIDTH-1:0] w_t_dbl;
   logic [DATA_WIDTH-1:0] w_t_sum;
   logic [DATA_WIDTH-1:0] w_t_nxt;
   logic [DATA_WIDTH-1:0] w_dig_red;
   logic [DATA_WIDTH-1:0] w_top_red;
   logic [DATA_WIDTH-1:0] w_acc_add;

   assign w_t_dbl   = f_cond_sub({r_t, 1'b0});
   assign w_t_sum   = f_cond_sub({1'b0, w_t_dbl} + {1'b0, r_acc});
   assign w_t_nxt   = i_bit ? w_t_sum : w_t_dbl;
   assign w_dig_red = f_cond_sub({1'b0, i_dig});
   assign w_top_red = f_cond_sub({1'b0, i_top});
   assign w_acc_add = f_cond_sub({1'b0, r_t} + {1'b0, w_dig_red});
   assign o_acc_nxt = w_acc_add;

   // t is cleared whenever a multiply is about to start (after INIT and after
   // every ADD), so the first MUL cycle starts from t = 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
         r_t   <= '0;
      end else if (i_init) begin
         r_acc <= w_top_red;
         r_t   <= '0;
      end else if (i_mul) begin
         r_t   <= w_t_nxt;
      end else if (i_add) begin
         r_acc <= w_acc_add;
         r_t   <= '0;
      end
   end

endmodule

// Top level.
//    state | meaning
//    IDLE  | waiting for a word, in_ready = 1
//    INIT  | acc <- a9 mod M on every channel
//    MUL   | DATA_WIDTH cycles: t <- acc * R_k mod M, radix bits MSB first
//    ADD   | acc <- (t + a_k) mod M; next k or finish
//    OUT   | result presented until out_ready
module mrd_to_rns_horner #(
   parameter int          DATA_WIDTH = 18,
   parameter int unsigned RADIX_4    = 262027,
   parameter int unsigned RADIX_5    = 262049,
   parameter int unsigned RADIX_6    = 262051,
   parameter int unsigned RADIX_7    = 262069,
   parameter int unsigned RADIX_8    = 262079,
   parameter int unsigned RADIX_9    = 262103,
   parameter int unsigned MOD_A      = 177147,
   parameter int unsigned MOD_B      = 262103,
   parameter int unsigned MOD_C      = 262079
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] Dig_in_4_,
   input  logic [DATA_WIDTH-1:0] Dig_in_5_,
   input  logic [DATA_WIDTH-1:0] Dig_in_6_,
   input  logic [DATA_WIDTH-1:0] Dig_in_7_,
   input  logic [DATA_WIDTH-1:0] Dig_in_8_,
   input  logic [DATA_WIDTH-1:0] Dig_in_9_,
   input  logic [1:0]            Sgn_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] Res_out_A,
   output logic [DATA_WIDTH-1:0] Res_out_B,
   output logic [DATA_WIDTH-1:0] Res_out_C,
   output logic [1:0]            Sgn_out,
   output logic                  Dig_err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_INIT = 3'd1;
   localparam logic [2:0] S_MUL  = 3'd2;
   localparam logic [2:0] S_ADD  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [DATA_WIDTH-1:0] LP_R4 = DATA_WIDTH'(RADIX_4);
   localparam logic [DATA_WIDTH-1:0] LP_R5 = DATA_WIDTH'(RADIX_5);
   localparam logic [DATA_WIDTH-1:0] LP_R6 = DATA_WIDTH'(RADIX_6);
   localparam logic [DATA_WIDTH-1:0] LP_R7 = DATA_WIDTH'(RADIX_7);
   localparam logic [DATA_WIDTH-1:0] LP_R8 = DATA_WIDTH'(RADIX_8);
   localparam logic [DATA_WIDTH-1:0] LP_R9 = DATA_WIDTH'(RADIX_9);

   localparam logic [CW-1:0] LP_BIT_LAST  = CW'(DATA_WIDTH-1);
   localparam logic [2:0]    LP_STEP_LAST = 3'd4;

   logic [2:0]            r_state;
   logic [CW-1:0]         r_bit_cnt;
   // r_step 0..4 selects k = 8..4
   logic [2:0]            r_step;
   // r_dig[0..5] hold a4..a9
   logic [DATA_WIDTH-1:0] r_dig [6];

   logic                  w_accept;
   logic                  w_dig_err;
   logic                  w_init;
   logic                  w_mul;
   logic                  w_add;
   logic                  w_last_add;
   logic [DATA_WIDTH-1:0] w_radix;
   logic [DATA_WIDTH-1:0] w_radix_sh;
   logic                  w_bit;
   logic [DATA_WIDTH-1:0] w_dig_k;
   logic [DATA_WIDTH-1:0] w_acc_nxt_a;
   logic [DATA_WIDTH-1:0] w_acc_nxt_b;
   logic [DATA_WIDTH-1:0] w_acc_nxt_c;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign w_accept  = in_valid & in_ready;

   assign w_dig_err = (Dig_in_4_ >= LP_R4) | (Dig_in_5_ >= LP_R5) |
                      (Dig_in_6_ >= LP_R6) | (Dig_in_7_ >= LP_R7) |
                      (Dig_in_8_ >= LP_R8) | (Dig_in_9_ >= LP_R9);

   assign w_init     = (r_state == S_INIT);
   assign w_mul      = (r_state == S_MUL);
   assign w_add      = (r_state == S_ADD);
   assign w_last_add = w_add & (r_step == LP_STEP_LAST);

   always_comb begin
      w_radix = LP_R4;
      w_dig_k = r_dig[0];
      case (r_step)
         3'd0: begin w_radix = LP_R8; w_dig_k = r_dig[4]; end
         3'd1: begin w_radix = LP_R7; w_dig_k = r_dig[3]; end
         3'd2: begin w_radix = LP_R6; w_dig_k = r_dig[2]; end
         3'd3: begin w_radix = LP_R5; w_dig_k = r_dig[1]; end
         default: begin w_radix = LP_R4; w_dig_k = r_dig[0]; end
      endcase
   end

   // Shifting the radix left by the bit count brings the current bit to the
   // MSB, giving the MSB-first scan without a variable bit index.
   assign w_radix_sh = w_radix << r_bit_cnt;
   assign w_bit      = w_radix_sh[DATA_WIDTH-1];

   mrd_to_rns_horner_ch #(.DATA_WIDTH(DATA_WIDTH), .MOD(MOD_A)) u_ch_a (
      .clk      (clk),
      .reset    (reset),
      .i_init   (w_init),
      .i_mul    (w_mul),
      .i_add    (w_add),
      .i_bit    (w_bit),
      .i_top    (r_dig[5]),
      .i_dig    (w_dig_k),
      .o_acc_nxt(w_acc_nxt_a)
   );

   mrd_to_rns_horner_ch #(.DATA_WIDTH(DATA_WIDTH), .MOD(MOD_B)) u_ch_b (
      .clk      (clk),
      .reset    (reset),
      .i_init   (w_init),
      .i_mul    (w_mul),
      .i_add    (w_add),
      .i_bit    (w_bit),
      .i_top    (r_dig[5]),
      .i_dig    (w_dig_k),
      .o_acc_nxt(w_acc_nxt_b)
   );

   mrd_to_rns_horner_ch #(.DATA_WIDTH(DATA_WIDTH), .MOD(MOD_C)) u_ch_c (
      .clk      (clk),
      .reset    (reset),
      .i_init   (w_init),
      .i_mul    (w_mul),
      .i_add    (w_add),
      .i_bit    (w_bit),
      .i_top    (r_dig[5]),
      .i_dig    (w_dig_k),
      .o_acc_nxt(w_acc_nxt_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_step    <= '0;
         Sgn_out   <= '0;
         Dig_err   <= 1'b0;
         for (int i = 0; i < 6; i++) r_dig[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dig[0] <= Dig_in_4_;
                  r_dig[1] <= Dig_in_5_;
                  r_dig[2] <= Dig_in_6_;
                  r_dig[3] <= Dig_in_7_;
                  r_dig[4] <= Dig_in_8_;
                  r_dig[5] <= Dig_in_9_;
                  Sgn_out  <= Sgn_in;
                  Dig_err  <= w_dig_err;
                  r_state  <= S_INIT;
               end
            end
            S_INIT: begin
               r_bit_cnt <= '0;
               r_step    <= '0;
               r_state   <= S_MUL;
            end
            S_MUL: begin
               if (r_bit_cnt == LP_BIT_LAST) begin
                  r_state <= S_ADD;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_ADD: begin
               r_bit_cnt <= '0;
               if (r_step == LP_STEP_LAST) begin
                  r_state <= S_OUT;
               end else begin
                  r_step  <= r_step + 1'b1;
                  r_state <= S_MUL;
               end
            end
            S_OUT: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Result registers load only on the final ADD, so they never show a
   // partial value and stay frozen through OUT regardless of stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         Res_out_A <= '0;
         Res_out_B <= '0;
         Res_out_C <= '0;
      end else if (w_last_add) begin
         Res_out_A <= w_acc_nxt_a;
         Res_out_B <= w_acc_nxt_b;
         Res_out_C <= w_acc_nxt_c;
      end
   end

endmodule

// File: tb/tb_mrd_to_rns_horner.sv
module tb_mrd_to_rns_horner;

   typedef logic [17:0] dig_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   dig_t        Dig_in_4_, Dig_in_5_, Dig_in_6_, Dig_in_7_, Dig_in_8_, Dig_in_9_;
   logic [1:0]  Sgn_in;
   logic        out_valid;
   logic        out_ready;
   dig_t        Res_out_A, Res_out_B, Res_out_C;
   logic [1:0]  Sgn_out;
   logic        Dig_err;

   mrd_to_rns_horner dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .Dig_in_4_(Dig_in_4_),
      .Dig_in_5_(Dig_in_5_),
      .Dig_in_6_(Dig_in_6_),
      .Dig_in_7_(Dig_in_7_),
      .Dig_in_8_(Dig_in_8_),
      .Dig_in_9_(Dig_in_9_),
      .Sgn_in   (Sgn_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Res_out_A(Res_out_A),
      .Res_out_B(Res_out_B),
      .Res_out_C(Res_out_C),
      .Sgn_out  (Sgn_out),
      .Dig_err  (Dig_err)
   );

   always #5 clk = ~clk;

   // radix[0..5] = R4..R9 (R9 is only a range limit)
   longint unsigned radix [6] = '{262027, 262049, 262051, 262069, 262079, 262103};
   longint unsigned mods  [3] = '{177147, 262103, 262079};

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   busy    = 0;
   bit   held_ok = 0;
   dig_t held_a, held_b, held_c;
   logic [1:0] held_s;
   logic held_e;

   // Full-precision value of the digit vector, then plain modulo.
   function automatic longint unsigned model_res(input dig_t d [6], input int ch);
      logic [127:0] x;
      x = 128'(d[5]);
      for (int k = 4; k >= 0; k--) x = x * 128'(radix[k]) + 128'(d[k]);
      return longint'(x % 128'(mods[ch]));
   endfunction

   function automatic bit model_err(input dig_t d [6]);
      bit e = 0;
      for (int k = 0; k < 6; k++) if (64'(d[k]) >= radix[k]) e = 1;
      return e;
   endfunction

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one cycle, sample 1 time unit after the edge and run the
   // per-cycle checks: in_ready low while a word is in flight and outputs
   // frozen for as long as out_valid stays high.
   task automatic tick();
      @(posedge clk);
      #1;
      if (busy) check("in_ready_low_busy", 64'(in_ready), 0);
      if (out_valid === 1'b1) begin
         if (held_ok) begin
            check("hold_A", 64'(Res_out_A), 64'(held_a));
            check("hold_B", 64'(Res_out_B), 64'(held_b));
            check("hold_C", 64'(Res_out_C), 64'(held_c));
            check("hold_sgn_err", 64'({Sgn_out, Dig_err}), 64'({held_s, held_e}));
         end
         held_a = Res_out_A; held_b = Res_out_B; held_c = Res_out_C;
         held_s = Sgn_out;   held_e = Dig_err;
         held_ok = 1;
      end else begin
         held_ok = 0;
      end
   endtask

   task automatic drive_digits(input dig_t d [6]);
      Dig_in_4_ = d[0]; Dig_in_5_ = d[1]; Dig_in_6_ = d[2];
      Dig_in_7_ = d[3]; Dig_in_8_ = d[4]; Dig_in_9_ = d[5];
   endtask

   task automatic accept_word(input dig_t d [6], input logic [1:0] sgn);
      int w = 0;
      while (in_ready !== 1'b1 && w < 20) begin tick(); w++; end
      check("in_ready_before_accept", 64'(in_ready), 1);
      drive_digits(d);
      Sgn_in   = sgn;
      in_valid = 1;
      tick();
      in_valid = 0;
      busy = 1;
   endtask

   task automatic run_word(input dig_t d [6], input logic [1:0] sgn, input int stall, input bit noise);
      int   cyc;
      dig_t junk [6];
      accept_word(d, sgn);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin
         if (noise) begin
            for (int k = 0; k < 6; k++) junk[k] = dig_t'($urandom);
            drive_digits(junk);
            in_valid = 1'($urandom_range(0, 1));
            Sgn_in   = 2'($urandom);
         end
         tick();
         cyc++;
      end
      in_valid = 0;
      check("latency", 64'(cyc), 96);
      check("res_A", 64'(Res_out_A), model_res(d, 0));
      check("res_B", 64'(Res_out_B), model_res(d, 1));
      check("res_C", 64'(Res_out_C), model_res(d, 2));
      check("sgn_out", 64'(Sgn_out), 64'(sgn));
      check("dig_err", 64'(Dig_err), 64'(model_err(d)));
      for (int s = 0; s < stall; s++) begin
         tick();
         check("valid_held", 64'(out_valid), 1);
      end
      busy = 0;
      out_ready = 1;
      tick();
      out_ready = 0;
      check("consume_valid_low", 64'(out_valid), 0);
      check("consume_ready_high", 64'(in_ready), 1);
   endtask

   task automatic do_reset();
      busy  = 0;
      reset = 1;
      tick();
      reset = 0;
   endtask

   dig_t dv [6];

   initial begin
      reset = 1; in_valid = 0; out_ready = 0; Sgn_in = 0;
      for (int k = 0; k < 6; k++) dv[k] = '0;
      drive_digits(dv);
      tick(); tick();
      do_reset();

      check("rst_in_ready", 64'(in_ready), 1);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_res", 64'({Res_out_A, Res_out_B, Res_out_C}), 0);
      check("rst_sgn_err", 64'({Sgn_out, Dig_err}), 0);

      // All digits zero
      run_word(dv, 2'b01, 0, 0);
      check("zero_A_lit", 64'(Res_out_A), 0);

      // a4 = 262026, a5 = 1 -> X = 524053
      dv[0] = 18'd262026; dv[1] = 18'd1;
      check("pin_524053_A", model_res(dv, 0), 169759);
      check("pin_524053_B", model_res(dv, 1), 261950);
      check("pin_524053_C", model_res(dv, 2), 261974);
      run_word(dv, 2'b10, 3, 0);

      // a4 = 5
      dv[0] = 18'd5; dv[1] = 18'd0;
      check("pin_5_A", model_res(dv, 0), 5);
      check("pin_5_C", model_res(dv, 2), 5);
      run_word(dv, 2'b00, 0, 0);

      // a5 = 1 -> X = 262027
      dv[0] = 18'd0; dv[1] = 18'd1;
      check("pin_r4_A", model_res(dv, 0), 84880);
      check("pin_r4_B", model_res(dv, 1), 262027);
      run_word(dv, 2'b11, 1, 0);

      // a4 = 262027 is out of range but still computed
      dv[0] = 18'd262027; dv[1] = 18'd0;
      check("pin_err_flag", 64'(model_err(dv)), 1);
      check("pin_err_A", model_res(dv, 0), 84880);
      run_word(dv, 2'b01, 0, 0);

      // Digits at top of range on every position
      for (int k = 0; k < 6; k++) dv[k] = dig_t'(radix[k] - 1);
      check("pin_top_err", 64'(model_err(dv)), 0);
      run_word(dv, 2'b10, 2, 1);

      // Reset 40 cycles into a computation
      dv[0] = 18'd1234; dv[1] = 18'd99; dv[2] = 18'd7; dv[3] = 18'd0; dv[4] = 18'd5; dv[5] = 18'd3;
      accept_word(dv, 2'b11);
      repeat (40) tick();
      do_reset();
      check("midrst_out_valid", 64'(out_valid), 0);
      check("midrst_in_ready", 64'(in_ready), 1);
      check("midrst_res", 64'({Res_out_A, Res_out_B, Res_out_C}), 0);
      run_word(dv, 2'b01, 0, 0);

      // Reset while holding a result in OUT
      accept_word(dv, 2'b10);
      repeat (100) begin
         if (out_valid !== 1'b1) tick();
      end
      check("outrst_reached_out", 64'(out_valid), 1);
      tick();
      do_reset();
      check("outrst_out_valid", 64'(out_valid), 0);
      check("outrst_in_ready", 64'(in_ready), 1);

      // Random in-range words with random stalls and in_valid noise while busy
      for (int n = 0; n < 500; n++) begin
         for (int k = 0; k < 6; k++) dv[k] = dig_t'($urandom_range(0, 32'(radix[k] - 1)));
         run_word(dv, 2'($urandom), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
